// File: rtl/cpu6502_io_responder.sv
// Board I/O responder for the cpu6502 data bus.
// Decodes a 16-byte window at BASE and exposes switches, keys, LEDs, 7-segment
// digits and a prescaled interval timer. Key presses and timer ticks can raise
// the active-low level interrupt irq_n.
module cpu6502_io_responder #(
    parameter logic [15:0] BASE     = 16'hD000,
    parameter int          PRESCALE = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        irq_n,
    input  logic [17:0] sw,
    input  logic [3:0]  key,
    output logic [17:0] ledr,
    output logic [7:0]  ledg,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    // Prescaler width; PRESCALE==1 still needs a one-bit counter that stays at 0.
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [3:0]    hex_nib [8];
    logic [15:0]   reload;
    logic [15:0]   count;
    logic [PW-1:0] pre;
    logic [2:0]    ctrl;
    logic          tf;
    logic [3:0]    kf;
    logic [3:0]    key_s1;
    logic [3:0]    key_s2;
    logic [3:0]    key_d;

    logic          sel;
    logic [3:0]    off;
    logic          wr_en;
    logic          ten_rise;
    logic          pre_done;
    logic          tick;
    logic          tf_clr;
    logic [3:0]    kf_clr;
    logic [3:0]    press;
    logic [7:0]    rd_mux;

    assign off      = addr[3:0];
    assign sel      = (addr[15:4] == BASE[15:4]);
    assign wr_en    = we & sel;
    assign ten_rise = wr_en && (off == 4'hE) && wdata[0] && !ctrl[0];
    assign pre_done = ctrl[0] && (pre == PRE_LAST);
    assign tick     = pre_done && (count == 16'd0);
    assign press    = key_d & ~key_s2;
    assign tf_clr   = wr_en && (off == 4'hF) && wdata[0];

    // Key flags may be cleared per bit at KEYSTAT or all at once via IRQSTAT bit1.
    always_comb begin
        kf_clr = 4'h0;
        if (wr_en && (off == 4'h3))
            kf_clr = wdata[3:0];
        else if (wr_en && (off == 4'hF) && wdata[1])
            kf_clr = 4'hF;
    end

    // Read data selection for the addressed register.
    always_comb begin
        rd_mux = 8'h00;
        case (off)
            4'h0: rd_mux = sw[7:0];
            4'h1: rd_mux = sw[15:8];
            4'h2: rd_mux = {6'b0, sw[17:16]};
            4'h3: rd_mux = {4'b0, kf};
            4'h4: rd_mux = ledg;
            4'h5: rd_mux = ledr[7:0];
            4'h6: rd_mux = ledr[15:8];
            4'h7: rd_mux = {6'b0, ledr[17:16]};
            4'h8, 4'h9, 4'hA, 4'hB:
                rd_mux = {hex_nib[{off[1:0], 1'b1}], hex_nib[{off[1:0], 1'b0}]};
            4'hC: rd_mux = reload[7:0];
            4'hD: rd_mux = reload[15:8];
            4'hE: rd_mux = {5'b0, ctrl};
            4'hF: rd_mux = {6'b0, |kf, tf};
            default: rd_mux = 8'h00;
        endcase
    end

    // Two-flop synchronizer plus one history stage for press edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            key_d  <= 4'hF;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    // CPU-writable output and configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ledr   <= '0;
            ledg   <= '0;
            reload <= 16'hFFFF;
            ctrl   <= '0;
            for (int i = 0; i < 8; i++) hex_nib[i] <= '0;
        end else if (wr_en) begin
            case (off)
                4'h4: ledg         <= wdata;
                4'h5: ledr[7:0]    <= wdata;
                4'h6: ledr[15:8]   <= wdata;
                4'h7: ledr[17:16]  <= wdata[1:0];
                4'h8, 4'h9, 4'hA, 4'hB: begin
                    hex_nib[{off[1:0], 1'b0}] <= wdata[3:0];
                    hex_nib[{off[1:0], 1'b1}] <= wdata[7:4];
                end
                4'hC: reload[7:0]  <= wdata;
                4'hD: reload[15:8] <= wdata;
                4'hE: ctrl         <= wdata[2:0];
                default: ;
            endcase
        end
    end

    // Interval timer: enabling loads a fresh period, otherwise it runs while TEN is set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre   <= '0;
            count <= 16'hFFFF;
        end else if (ten_rise) begin
            pre   <= '0;
            count <= reload;
        end else if (ctrl[0]) begin
            if (pre_done) begin
                pre   <= '0;
                count <= (count == 16'd0) ? reload : count - 16'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    // Event flags; a set in the same cycle as a clear keeps the flag high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tf <= 1'b0;
            kf <= 4'h0;
        end else begin
            tf <= (tf & ~tf_clr) | tick;
            kf <= (kf & ~kf_clr) | press;
        end
    end

    // Registered read data and interrupt line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= 8'h00;
            irq_n <= 1'b1;
        end else begin
            if (re) rdata <= sel ? rd_mux : 8'h00;
            irq_n <= ~((tf & ctrl[1]) | ((|kf) & ctrl[2]));
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex0 = seg7(hex_nib[0]);
    assign hex1 = seg7(hex_nib[1]);
    assign hex2 = seg7(hex_nib[2]);
    assign hex3 = seg7(hex_nib[3]);
    assign hex4 = seg7(hex_nib[4]);
    assign hex5 = seg7(hex_nib[5]);
    assign hex6 = seg7(hex_nib[6]);
    assign hex7 = seg7(hex_nib[7]);

endmodule
